// File: rtl/mat_operand_packer.sv
// mat_operand_packer: packs a descriptor plus row-major element stream into flat A/B operands and sequences the matrix engine.
// Define DIM_PRECHECK_EN to also reject shape-incompatible descriptors at acceptance.
module mat_operand_packer #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [2:0]                        cfg_op,
    input  logic [2:0]                        cfg_dim_a_m,
    input  logic [2:0]                        cfg_dim_a_n,
    input  logic [2:0]                        cfg_dim_b_m,
    input  logic [2:0]                        cfg_dim_b_n,
    input  logic [7:0]                        cfg_scalar,
    input  logic                              elem_valid,
    output logic                              elem_ready,
    input  logic [ELEM_W-1:0]                 elem_data,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrix_a_flat,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrix_b_flat,
    output logic [2:0]                        dim_a_m,
    output logic [2:0]                        dim_a_n,
    output logic [2:0]                        dim_b_m,
    output logic [2:0]                        dim_b_n,
    output logic [2:0]                        op_sel,
    output logic [7:0]                        scalar_k,
    output logic                              start_op,
    input  logic                              op_done,
    input  logic                              error_flag,
    input  logic                              busy_flag,
    output logic                              seq_done,
    output logic                              seq_error,
    output logic [1:0]                        err_code
);
    localparam int NSLOT = MAX_DIM * MAX_DIM;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LAUNCH, WAIT, FINISH, FAULT} state_t;

    state_t        state, state_n;
    logic [4:0]    idx, need_a, need_b;
    logic [CW-1:0] cnt;
    logic [1:0]    fault_code;
    logic          range_ok, shape_ok, accept, take, last, two_op;
    logic          unused_ok;

    assign unused_ok = busy_flag;

    function automatic logic in_range(input logic [2:0] d);
        return d != 3'd0 && d <= 3'(MAX_DIM);
    endfunction

    assign range_ok = in_range(cfg_dim_a_m) && in_range(cfg_dim_a_n) &&
                      in_range(cfg_dim_b_m) && in_range(cfg_dim_b_n);

`ifdef DIM_PRECHECK_EN
    assign shape_ok = cfg_op == 3'b001 ? (cfg_dim_a_m == cfg_dim_b_m && cfg_dim_a_n == cfg_dim_b_n) :
                      cfg_op == 3'b011 ? (cfg_dim_a_n == cfg_dim_b_m) :
                      cfg_op == 3'b100 ? (cfg_dim_b_m <= cfg_dim_a_m && cfg_dim_b_n <= cfg_dim_a_n) :
                      1'b1;
`else
    assign shape_ok = 1'b1;
`endif

    assign need_a = 5'(dim_a_m) * 5'(dim_a_n);
    assign need_b = 5'(dim_b_m) * 5'(dim_b_n);
    assign two_op = op_sel == 3'b001 || op_sel == 3'b011 || op_sel == 3'b100;
    assign accept = state == IDLE && cfg_valid;
    assign take   = elem_valid && elem_ready;
    assign last   = idx == (state == LOAD_B ? need_b : need_a) - 5'd1;

    assign cfg_ready  = state == IDLE;
    assign elem_ready = state == LOAD_A || state == LOAD_B;
    assign seq_done   = state == FINISH;
    assign seq_error  = state == FAULT;
    // Engine faults need a start_op to walk the engine out of its ERROR state.
    assign start_op   = state == LAUNCH || (state == FAULT && err_code[1]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        fault_code = 2'b00;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_n    = range_ok && shape_ok ? LOAD_A : FAULT;
                    fault_code = range_ok && shape_ok ? 2'b00 : 2'b01;
                end
            end
            LOAD_A: if (take && last) state_n = two_op ? LOAD_B : LAUNCH;
            LOAD_B: if (take && last) state_n = LAUNCH;
            LAUNCH: state_n = WAIT;
            WAIT: begin
                if (error_flag) begin
                    state_n    = FAULT;
                    fault_code = 2'b10;
                end else if (op_done) begin
                    state_n = FINISH;
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    state_n    = FAULT;
                    fault_code = 2'b11;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_a_flat <= '0;
            matrix_b_flat <= '0;
            dim_a_m       <= '0;
            dim_a_n       <= '0;
            dim_b_m       <= '0;
            dim_b_n       <= '0;
            op_sel        <= '0;
            scalar_k      <= '0;
            err_code      <= '0;
            idx           <= '0;
            cnt           <= '0;
        end else begin
            if (accept) begin
                matrix_a_flat <= '0;
                matrix_b_flat <= '0;
                dim_a_m       <= cfg_dim_a_m;
                dim_a_n       <= cfg_dim_a_n;
                dim_b_m       <= cfg_dim_b_m;
                dim_b_n       <= cfg_dim_b_n;
                op_sel        <= cfg_op;
                scalar_k      <= cfg_scalar;
            end
            if (accept || state_n == FAULT) err_code <= fault_code;
            idx <= accept ? 5'd0 : take ? (last ? 5'd0 : idx + 5'd1) : idx;
            cnt <= state == WAIT ? cnt + CW'(1) : '0;
            for (int i = 0; i < NSLOT; i++) begin
                if (take && idx == 5'(i)) begin
                    if (state == LOAD_A) matrix_a_flat[i*ELEM_W +: ELEM_W] <= elem_data;
                    else                 matrix_b_flat[i*ELEM_W +: ELEM_W] <= elem_data;
                end
            end
        end
    end
endmodule

// File: doc/mat_operand_packer.md
Name: mat_operand_packer

Overview:
Initiator side of the matrix-engine operand interface. Accepts an operation descriptor and a serial row-major element stream from the input parser, packs the elements into the flat A/B operand buses, and launches the engine with a one-cycle start_op. It then waits for the engine's op_done or error_flag, clears the engine's error state when needed, and reports completion or fault upstream.

Parameters:
MAX_DIM, 5, maximum rows and columns per operand; the flat buses hold MAX_DIM*MAX_DIM elements.
ELEM_W, 8, element width in bits (signed two's complement, passed through unmodified).
TIMEOUT, 1024, cycles allowed in WAIT before a timeout fault.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  descriptor offered
cfg_ready  out  1  high only in IDLE
cfg_op  in  3  000 T, 001 A, 010 b, 011 C, 100 J
cfg_dim_a_m, cfg_dim_a_n, cfg_dim_b_m, cfg_dim_b_n  in  3 each  operand dimensions
cfg_scalar  in  8  signed scalar k
elem_valid  in  1  element offered
elem_ready  out  1  high in LOAD_A and LOAD_B
elem_data  in  ELEM_W  element value
matrix_a_flat, matrix_b_flat  out  ELEM_W*MAX_DIM*MAX_DIM  packed operands; element idx occupies bits [idx*ELEM_W +: ELEM_W]
dim_a_m, dim_a_n, dim_b_m, dim_b_n  out  3 each  latched dimensions
op_sel  out  3  latched operation
scalar_k  out  8  latched scalar
start_op  out  1  one-cycle engine launch or clear pulse
op_done, error_flag, busy_flag  in  1 each  engine status
seq_done  out  1  one-cycle success pulse
seq_error  out  1  one-cycle fault pulse
err_code  out  2  00 none, 01 bad descriptor, 10 engine error, 11 timeout

Behaviour:
- Reset: all outputs are 0; the state machine returns to IDLE. Reset applies from any state, including mid-load and during WAIT; start_op is never asserted in the cycle after rst.
- IDLE: cfg_ready=1. On cfg_valid, latch op, dims and scalar, zero both flat buses, and clear err_code.
  - If any dimension is 0 or greater than MAX_DIM, go to FAULT with code 01.
  - Otherwise go to LOAD_A.
- LOAD_A: elem_ready=1. Each elem_valid&&elem_ready writes slot idx, then idx increments. After element dim_a_m*dim_a_n-1:
  - ops 001/011/100 go to LOAD_B with idx reset to 0;
  - ops 000/010 go to LAUNCH, and matrix_b_flat stays all zero.
- LOAD_B: identical to LOAD_A, using dim_b_m*dim_b_n elements. Then go to LAUNCH.
- Element handshake: elem_valid while elem_ready=0 is ignored and never written. The element count uses 5 bits, for a maximum of 25 elements.
- LAUNCH: start_op=1 for exactly one cycle. Go to WAIT and clear the timeout counter.
- WAIT: the counter increments every cycle.
  - error_flag goes to FAULT with code 10. If error_flag and op_done are sampled in the same cycle, error wins.
  - op_done goes to FINISH.
  - When the counter reaches TIMEOUT-1, go to FAULT with code 11.
  - busy_flag is status only and does not drive transitions.
- FINISH: seq_done=1 for one cycle, then go to IDLE.
- FAULT: seq_error=1 for one cycle.
  - Codes 10 and 11 also drive start_op=1 in this cycle, which returns the engine from its ERROR state to IDLE.
  - Code 01 never drives start_op.
  - Next state is IDLE. err_code holds until the next descriptor is accepted.
- Operand bus and dimension outputs stay stable from the end of the load until the next descriptor is accepted.

Optional Feature:
DIM_PRECHECK_EN.
- Defined: at descriptor acceptance, also check operand compatibility. A requires equal dims; C requires a_n==b_m; J requires b_m<=a_m and b_n<=a_n. A failure goes to FAULT with code 01: no elements are accepted and there is no launch.
- Undefined: only the range check runs. Incompatible descriptors load and launch normally, and the engine's error_flag is reported as code 10.

Test Plan:
1. Transpose (000), 2x3 A, elements 1..6.
   - Exactly 6 elements accepted, then elem_ready=0.
   - matrix_a_flat[47:0]=0x060504030201, all other bits 0; matrix_b_flat=0.
   - One start_op pulse; engine op_done gives seq_done=1 for one cycle.
2. Multiply (011), 2x2 by 2x2, A=1,2,3,4 and B=5,6,7,8.
   - 8 elements accepted.
   - matrix_b_flat[31:0]=0x08070605.
   - elem_valid held high after the 8th element writes nothing further.
3. Descriptor with dim_a_m=0 or dim_b_n=6 gives seq_error pulse, err_code=01, and start_op stays 0 throughout.
4. Add (001), A 2x2 vs B 3x3.
   - Macro off: 13 elements load, launch, error_flag gives err_code=10 plus a start_op clear pulse in the same cycle as seq_error.
   - Macro on: err_code=01 with zero elements accepted.
5. TIMEOUT=16 with op_done never asserted gives seq_error and err_code=11 exactly 16 cycles after LAUNCH, with a clear start_op pulse.
6. rst asserted after 3 of 6 elements.
   - All outputs 0 and cfg_ready=1 next cycle.
   - A new descriptor loads from slot 0.
